// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle SLL/SRL/SRA shifter, up to STEP bits per clock.
// Define SHIFTER_ROTATE_EN to add ROL/ROR selected by i_rot.
module shifter_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk_n,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [SHW-1:0]  i_in_b,
    input  logic [2:0]      i_funct3,
    input  logic            i_op_alt,
    input  logic            i_rot,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic            o_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // STEP may equal XLEN; the remaining count never exceeds XLEN-1,
    // so clamping the per-cycle cap there keeps it in SHW bits.
    localparam int STEPC = (STEP < XLEN) ? STEP : XLEN - 1;
    localparam logic [SHW-1:0] STEPW = SHW'(STEPC);

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [SHW-1:0]  rem_q, rem_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;
    logic            sign_q, sign_d;
    logic            rot_q, rot_d;

    logic            accept;
    logic            is_sh;
    logic            rot_en;
    logic [SHW-1:0]  k;
    logic [XLEN-1:0] sll_v, srl_v, sra_v, step_v;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [SHW:0] XLEN_W = (SHW + 1)'(XLEN);
    logic [SHW:0]    k_inv;
    logic [XLEN-1:0] rol_v, ror_v;
    assign rot_en = i_rot;
`else
    logic unused_rot;
    assign unused_rot = i_rot;
    assign rot_en     = 1'b0;
`endif

    // Datapath for one iteration: shift the held result by k positions.
    always_comb begin
        k      = (rem_q > STEPW) ? STEPW : rem_q;
        sll_v  = res_q << k;
        srl_v  = res_q >> k;
        sra_v  = srl_v | (~({XLEN{1'b1}} >> k) & {XLEN{sign_q}});
`ifdef SHIFTER_ROTATE_EN
        k_inv  = XLEN_W - {1'b0, k};
        rol_v  = sll_v | (res_q >> k_inv);
        ror_v  = srl_v | (res_q << k_inv);
        if (rot_q) begin
            step_v = left_q ? rol_v : ror_v;
        end else begin
            step_v = left_q ? sll_v : (arith_q ? sra_v : srl_v);
        end
`else
        step_v = left_q ? sll_v : (arith_q ? sra_v : srl_v);
`endif
    end

    // Next-state logic: iterate in SHIFT, accept new work in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rem_d   = rem_q;
        left_d  = left_q;
        arith_d = arith_q;
        sign_d  = sign_q;
        rot_d   = rot_q;
        accept  = i_start && (state_q == S_IDLE || state_q == S_DONE);
        is_sh   = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

        unique case (state_q)
            S_SHIFT: begin
                res_d = step_v;
                rem_d = rem_q - k;
                if (rem_q == k) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            left_d  = (i_funct3 == 3'b001);
            arith_d = i_op_alt;
            sign_d  = i_in_a[XLEN-1];
            rot_d   = rot_en && is_sh;
            res_d   = i_in_a;
            rem_d   = is_sh ? i_in_b : '0;
            if (is_sh && i_in_b != '0) state_d = S_SHIFT;
            else                       state_d = S_DONE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            arith_q <= arith_d;
            sign_q  <= sign_d;
            rot_q   <= rot_d;
        end
    end

    assign o_result = res_q;
    assign o_busy   = (state_q == S_SHIFT);
    assign o_valid  = (state_q == S_DONE);

endmodule

// File: tb/tb_shifter_iter.sv
// tb_shifter_iter: scoreboard bench for shifter_iter, STEP=1 and STEP=4.
// Expected results are queued at start and popped on o_valid.
module tb_shifter_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  f3;
    logic        op_alt, rot;
    logic [31:0] res1, res4;
    logic        busy1, busy4, valid1, valid4;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    shifter_iter #(.XLEN(32), .STEP(1)) dut1 (
        .i_clk_n(clk), .i_rst(rst), .i_start(start1),
        .i_in_a(a), .i_in_b(b), .i_funct3(f3),
        .i_op_alt(op_alt), .i_rot(rot),
        .o_result(res1), .o_busy(busy1), .o_valid(valid1)
    );

    shifter_iter #(.XLEN(32), .STEP(4)) dut4 (
        .i_clk_n(clk), .i_rst(rst), .i_start(start4),
        .i_in_a(a), .i_in_b(b), .i_funct3(f3),
        .i_op_alt(op_alt), .i_rot(rot),
        .o_result(res4), .o_busy(busy4), .o_valid(valid4)
    );

    function automatic logic [31:0] model(input logic [31:0] ia,
                                          input logic [4:0] n,
                                          input logic [2:0] fn,
                                          input logic alt,
                                          input logic r);
        logic re;
        int   sh;
`ifdef SHIFTER_ROTATE_EN
        re = r;
`else
        re = r & 1'b0;
`endif
        sh = int'(n);
        if (fn == 3'b001) begin
            if (re) return (ia << sh) | (ia >> (32 - sh));
            return ia << sh;
        end
        if (fn == 3'b101) begin
            if (re)  return (ia >> sh) | (ia << (32 - sh));
            if (alt) return $unsigned($signed(ia) >>> sh);
            return ia >> sh;
        end
        return ia;
    endfunction

    function automatic int exp_busy(input bit sel, input logic [4:0] n,
                                    input logic [2:0] fn);
        int st;
        st = sel ? 4 : 1;
        if ((fn == 3'b001 || fn == 3'b101) && n != 0)
            return (int'(n) + st - 1) / st;
        return 0;
    endfunction

    task automatic drive(input bit sel, input logic [31:0] ia,
                         input logic [4:0] n, input logic [2:0] fn,
                         input logic alt, input logic r);
        a = ia; b = n; f3 = fn; op_alt = alt; rot = r;
        if (sel) start4 = 1'b1;
        else     start1 = 1'b1;
        sb_q.push_back(model(ia, n, fn, alt, r));
    endtask

    task automatic run_op(input string name, input bit sel,
                          input logic [31:0] ia, input logic [4:0] n,
                          input logic [2:0] fn, input logic alt,
                          input logic r, input bit skip, input int glitch);
        int cyc, bc, eb;
        bit to;
        logic [31:0] exp_r, got;
        if (!skip) @(negedge clk);
        drive(sel, ia, n, fn, alt, r);
        eb = exp_busy(sel, n, fn);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        cyc = 1; bc = 0; to = 1'b0;
        while (!(sel ? valid4 : valid1)) begin
            if (sel ? busy4 : busy1) bc++;
            if (cyc == glitch) begin
                a = ~a; b = 5'd2; f3 = 3'b101;
                if (sel) start4 = 1'b1;
                else     start1 = 1'b1;
            end else begin
                start1 = 1'b0; start4 = 1'b0;
            end
            cyc++;
            if (cyc > 100) begin to = 1'b1; break; end
            @(negedge clk);
        end
        start1 = 1'b0; start4 = 1'b0;
        got = sel ? res4 : res1;
        tests_run++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout: no valid after %0d cycles", name, cyc);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: empty queue, got %h", name, got);
        end else begin
            exp_r = sb_q.pop_front();
            if (got !== exp_r) begin
                fails++;
                $display("FAIL %s result: got %h want %h", name, got, exp_r);
            end
        end
        tests_run++;
        if (!to && bc !== eb) begin
            fails++;
            $display("FAIL %s busy: got %0d want %0d", name, bc, eb);
        end
        tests_run++;
        if (!to && cyc !== eb + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, eb + 1);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy1, valid1, res1} !== 34'd0) begin
            fails++;
            $display("FAIL reset1: got %b %b %h want 0 0 0",
                     busy1, valid1, res1);
        end
        tests_run++;
        if ({busy4, valid4, res4} !== 34'd0) begin
            fails++;
            $display("FAIL reset4: got %b %b %h want 0 0 0",
                     busy4, valid4, res4);
        end
    endtask

    task automatic test_shifts();
        run_op("sll1", 0, 32'h0000_0001, 5'd4, 3'b001, 0, 0, 0, 0);
        run_op("sra4", 1, 32'h8000_0000, 5'd31, 3'b101, 1, 0, 0, 0);
        run_op("srl4", 1, 32'h8000_0000, 5'd31, 3'b101, 0, 0, 0, 0);
        run_op("sll4", 1, 32'h1234_5678, 5'd6, 3'b001, 0, 0, 0, 0);
        run_op("sra1", 0, 32'hF000_0F00, 5'd5, 3'b101, 1, 0, 0, 0);
        run_op("rot4", 1, 32'h0000_0001, 5'd1, 3'b101, 0, 1, 0, 0);
        run_op("rol1", 0, 32'h8000_0001, 5'd3, 3'b001, 0, 1, 0, 0);
    endtask

    task automatic test_passthru();
        run_op("n0", 1, 32'hDEAD_BEEF, 5'd0, 3'b001, 0, 0, 0, 0);
        run_op("f000", 0, 32'hDEAD_BEEF, 5'd9, 3'b000, 0, 0, 0, 0);
        run_op("f011", 1, 32'hCAFE_F00D, 5'd7, 3'b011, 1, 1, 0, 0);
    endtask

    task automatic test_hold();
        run_op("hold", 1, 32'h0F0F_0F0F, 5'd8, 3'b101, 0, 0, 0, 0);
        @(negedge clk);
        tests_run++;
        if (valid4 !== 1'b0 || res4 !== 32'h000F_0F0F) begin
            fails++;
            $display("FAIL hold: got v=%b r=%h want v=0 r=000f0f0f",
                     valid4, res4);
        end
    endtask

    task automatic test_ignore_start();
        run_op("ignore", 0, 32'h0000_0001, 5'd10, 3'b001, 0, 0, 0, 3);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_a", 0, 32'h0000_0001, 5'd3, 3'b001, 0, 0, 0, 0);
        run_op("b2b_b", 0, 32'h0000_0080, 5'd2, 3'b101, 0, 0, 1, 0);
        run_op("b2b_c", 0, 32'h1111_2222, 5'd2, 3'b110, 0, 0, 1, 0);
        run_op("b2b_d", 1, 32'h8000_0000, 5'd9, 3'b101, 1, 0, 0, 0);
        run_op("b2b_e", 1, 32'h0000_0003, 5'd4, 3'b001, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        drive(0, 32'h0000_0001, 5'd20, 3'b001, 0, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({busy1, valid1, res1} !== 34'd0) begin
            fails++;
            $display("FAIL rst_mid: got %b %b %h want 0 0 0",
                     busy1, valid1, res1);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            fails++;
            $display("FAIL rst_mid_valid: got pulse want none");
        end
    endtask

    task automatic test_reset_start();
        @(negedge clk);
        a = 32'h5555_5555; b = 5'd0; f3 = 3'b000;
        rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
        tests_run++;
        if (valid1 !== 1'b0 || res1 !== 32'd0 ||
            valid4 !== 1'b0 || res4 !== 32'd0) begin
            fails++;
            $display("FAIL rst_start: got v=%b%b r=%h/%h want 0",
                     valid1, valid4, res1, res4);
        end
    endtask

    task automatic test_random();
        logic [2:0] fns [4];
        fns[0] = 3'b001; fns[1] = 3'b101; fns[2] = 3'b000; fns[3] = 3'b101;
        for (int i = 0; i < 20; i++) begin
            run_op("rand", 1'($urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 31)), fns[$urandom_range(0, 3)],
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; f3 = '0; op_alt = 1'b0; rot = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_shifts();
        test_passthru();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_reset_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/shifter_iter.md
# shifter_iter

Parametrised multi-cycle shifter for the CPU execute stage, the next generation of the single-bit sequential shifter. It shifts an XLEN-bit operand left, logically right or arithmetically right, and optionally rotates, by up to STEP bit positions per clock. It uses an explicit start/busy/valid handshake so the pipeline controller can stall on it. Area scales with STEP, which lets a build trade cycles against LUTs without changing the surrounding logic.

## Interface
Parameters:
- XLEN, 32: operand width; legal values 32, 64.
- STEP, 1: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ XLEN.
- SHW, $clog2(XLEN): shift-amount width (derived; do not override).

Ports (one clock; reset is synchronous and active-high):
- i_clk_n  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request; sampled only in IDLE or DONE.
- i_in_a  in  XLEN  operand.
- i_in_b  in  SHW  shift amount n (unsigned).
- i_funct3  in  3  001 = left, 101 = right; any other value = pass-through.
- i_op_alt  in  1  right shifts: 0 = SRL, 1 = SRA.
- i_rot  in  1  rotate select (only active with SHIFTER_ROTATE_EN).
- o_result  out  XLEN  registered result; holds until the next accepted start.
- o_busy  out  1  high while in SHIFT (pipeline stall).
- o_valid  out  1  one-cycle pulse; o_result is final.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: i_start && (IDLE || DONE) at a rising edge. On accept:
  - latch the operation;
  - o_result ← i_in_a;
  - remaining ← n;
  - next state is SHIFT if n ≠ 0 and the operation is a shift or rotate, else DONE.
- Pass-through: funct3 ∉ {001, 101} forces remaining = 0. Result is i_in_a.
- SHIFT, each edge:
  - k = min(STEP, remaining);
  - o_result ← op(o_result, k);
  - remaining ← remaining − k;
  - go to DONE when remaining reaches 0.
- Operations:
  - SLL fills with zeros from the LSB.
  - SRL fills with zeros from the MSB.
  - SRA fills with the latched operand's bit XLEN−1.
  - ROL and ROR wrap bits around.
- DONE: o_valid = 1 for this cycle. Next edge goes to IDLE, unless a new start is accepted, which follows the accept rules above (back-to-back operations).
- i_start in SHIFT is ignored. Inputs are not sampled after accept, so they may change freely.
- Arithmetic: remaining is SHW bits. k ≤ remaining, so remaining never underflows. Amounts ≥ XLEN cannot be expressed.

## Timing
- Reset values: state = IDLE, o_result = 0, o_busy = 0, o_valid = 0, remaining = 0.
- Latency from the accept edge E0: o_valid is high in the cycle following edge E0 + ceil(n/STEP).
  - For n = 0 or pass-through: the cycle right after E0.
- o_busy is high for exactly ceil(n/STEP) cycles, beginning the cycle after E0.
- Throughput: one operation per ceil(n/STEP) + 1 cycles, using back-to-back start in DONE.
- Reset mid-operation: next cycle is IDLE. The aborted operation never produces o_valid, and o_result = 0.
- Reset and i_start in the same cycle: reset wins and the start is dropped.

## Configuration
- SHIFTER_ROTATE_EN defined:
  - i_rot = 1 with funct3 001 → ROL; with funct3 101 → ROR.
  - i_op_alt is ignored for rotates.
- SHIFTER_ROTATE_EN undefined:
  - i_rot is ignored (treated as 0) and no rotate logic is synthesised.
  - The same inputs perform SLL/SRL/SRA.

## Test plan
- XLEN=32, STEP=1: SLL a=0x00000001, n=4 → o_busy high 4 cycles, o_valid in cycle 5 after accept, o_result=0x00000010.
- STEP=4: SRA a=0x80000000, n=31 → o_busy 8 cycles, o_result=0xFFFFFFFF. The same with SRL → 0x00000001.
- n=0, and separately funct3=000 with a=0xDEADBEEF → o_busy never asserts, o_valid next cycle, o_result=0xDEADBEEF.
- ROR a=0x00000001, n=1, i_rot=1 → 0x80000000 with SHIFTER_ROTATE_EN. Without it → SRL result 0x00000000.
- STEP=1, SLL n=10: pulse i_start again at cycle 3 with different operands → ignored, result 0x400 for a=1. A new start in the DONE cycle is accepted back-to-back.
- Assert i_rst at cycle 2 of an n=20 shift → next cycle IDLE, o_busy=0, o_result=0, no o_valid pulse ever.
